// File: rtl/gpu_pkg.sv
// Shared GPU pipeline types: frame sequencer states and default timing constants.
package gpu_pkg;

   typedef enum logic [1:0] {
      WaitSwitch,
      WaitBuffer,
      Render
   } frame_state_t;

   localparam int FRAME_PERIOD_DEFAULT = 2_000_000;
   localparam int HOLDOFF_DEFAULT      = 100;

endpackage

// File: rtl/frame_timer.sv
// Free-running frame period counter; tick_out is high during the final count of each
// period so that registered consumers change state exactly at the wrap.
module frame_timer
   import gpu_pkg::*;
#(
   parameter int PERIOD = FRAME_PERIOD_DEFAULT
) (
   input  logic clk_in,
   input  logic rst_in,
   output logic tick_out
);

   localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(PERIOD - 1);
   localparam logic [CW-1:0] PRE_COUNT  = CW'(PERIOD - 2);

   logic [CW-1:0] count;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         count    <= '0;
         tick_out <= 1'b0;
      end else begin
         count    <= (count == LAST_COUNT) ? '0 : count + CW'(1);
         tick_out <= (count == PRE_COUNT);
      end
   end

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame control sequencer: buffer rotation, pipeline restart strobes and frame statistics.
// Define FRAME_SEQ_STATS_EN to build the pixel, last-pixel and overrun counters.
module frame_sequencer
   import gpu_pkg::*;
#(
   parameter int FRAME_PERIOD   = FRAME_PERIOD_DEFAULT,
   parameter int NUM_BUFFERS    = 2,
   parameter int HOLDOFF_CYCLES = HOLDOFF_DEFAULT,
   parameter int COUNT_WIDTH    = 16
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           fb_ready_in,
   input  logic                           pixel_valid_in,
   input  logic                           done_in,
   output logic                           fb_switch_out,
   output logic                           fb_clear_out,
   output logic [$clog2(NUM_BUFFERS)-1:0] buffer_index_out,
   output logic                           matrix_rst_out,
   output logic                           fetch_rst_out,
   output logic [COUNT_WIDTH-1:0]         pixel_count_out,
   output logic [COUNT_WIDTH-1:0]         last_pixel_count_out,
   output logic [COUNT_WIDTH-1:0]         frame_count_out,
   output logic [COUNT_WIDTH-1:0]         overrun_count_out
);

   localparam int IDX_W  = $clog2(NUM_BUFFERS);
   localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 2);
   localparam logic [HOLD_W-1:0] HOLD_TARGET = HOLD_W'(HOLDOFF_CYCLES);
   localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_BUFFERS - 1);

   frame_state_t      state, state_next;
   logic              tick;
   logic              enter_render;
   logic              matrix_rst_next, fetch_rst_next;
   logic [HOLD_W-1:0] holdoff, holdoff_next;

   frame_timer #(.PERIOD(FRAME_PERIOD)) u_timer (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .tick_out (tick)
   );

   // The clear pulse doubles as the reset-time clear, hence its reset value of 1.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         fb_switch_out    <= 1'b0;
         fb_clear_out     <= 1'b1;
         buffer_index_out <= '0;
      end else begin
         fb_switch_out <= tick;
         fb_clear_out  <= tick;
         if (tick)
            buffer_index_out <= (buffer_index_out == LAST_IDX) ? '0 : buffer_index_out + IDX_W'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state           <= WaitSwitch;
         holdoff         <= '0;
         matrix_rst_out  <= 1'b0;
         fetch_rst_out   <= 1'b1;
         frame_count_out <= '0;
      end else begin
         state          <= state_next;
         holdoff        <= holdoff_next;
         matrix_rst_out <= matrix_rst_next;
         fetch_rst_out  <= fetch_rst_next;
         if (enter_render)
            frame_count_out <= frame_count_out + COUNT_WIDTH'(1);
      end
   end

   // A switch overrides everything: it restarts the hold-off from any state.
   always_comb begin
      state_next      = state;
      holdoff_next    = holdoff;
      matrix_rst_next = 1'b0;
      fetch_rst_next  = fetch_rst_out;
      enter_render    = 1'b0;
      case (state)
         WaitSwitch: ;
         WaitBuffer: begin
            if (holdoff < HOLD_TARGET)
               holdoff_next = holdoff + HOLD_W'(1);
            if (holdoff >= HOLD_TARGET && fb_ready_in) begin
               enter_render   = 1'b1;
               fetch_rst_next = 1'b0;
               state_next     = Render;
            end
         end
         Render: begin
            if (done_in)
               state_next = WaitSwitch;
         end
         default: state_next = WaitSwitch;
      endcase
      if (tick) begin
         state_next      = WaitBuffer;
         holdoff_next    = '0;
         matrix_rst_next = 1'b1;
         fetch_rst_next  = 1'b1;
         enter_render    = 1'b0;
      end
   end

`ifdef FRAME_SEQ_STATS_EN
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

   logic [COUNT_WIDTH-1:0] pixel_acc;

   assign pixel_acc = (pixel_valid_in && pixel_count_out != COUNT_MAX)
                      ? pixel_count_out + COUNT_WIDTH'(1) : pixel_count_out;

   // The latched total includes a pixel arriving in the same cycle as done or the switch.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pixel_count_out      <= '0;
         last_pixel_count_out <= '0;
         overrun_count_out    <= '0;
      end else if (enter_render) begin
         pixel_count_out <= '0;
      end else if (state == Render) begin
         pixel_count_out <= pixel_acc;
         if (done_in || tick)
            last_pixel_count_out <= pixel_acc;
         if (tick && !done_in && overrun_count_out != COUNT_MAX)
            overrun_count_out <= overrun_count_out + COUNT_WIDTH'(1);
      end
   end
`else
   logic unused_stats;

   assign unused_stats         = pixel_valid_in;
   assign pixel_count_out      = '0;
   assign last_pixel_count_out = '0;
   assign overrun_count_out    = '0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: cycle-indexed reference model plus directed literal checks.
module tb_frame_sequencer;

   localparam int P = 50;
   localparam int H = 4;
   localparam int N = 3;
   localparam int W = 8;
   localparam int CMAX = 255;
`ifdef FRAME_SEQ_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, ready, valid, done;
   logic switch_o, clear_o, matrix_o, fetch_o;
   logic [1:0] idx_o;
   logic [W-1:0] pix_o, last_o, frame_o, over_o;

   logic rst_l, valid_l;
   logic ready_l = 1'b1;
   logic done_l = 1'b0;
   logic l_switch, l_clear, l_matrix, l_fetch;
   logic [1:0] l_idx;
   logic [W-1:0] l_pix, l_last, l_frame, l_over;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   frame_sequencer #(.FRAME_PERIOD(P), .NUM_BUFFERS(N), .HOLDOFF_CYCLES(H), .COUNT_WIDTH(W)) dut (
      .clk_in(clk), .rst_in(rst), .fb_ready_in(ready), .pixel_valid_in(valid), .done_in(done),
      .fb_switch_out(switch_o), .fb_clear_out(clear_o), .buffer_index_out(idx_o),
      .matrix_rst_out(matrix_o), .fetch_rst_out(fetch_o), .pixel_count_out(pix_o),
      .last_pixel_count_out(last_o), .frame_count_out(frame_o), .overrun_count_out(over_o)
   );

   // Long-period instance: the only way to fit 300 pixels into a single frame.
   frame_sequencer #(.FRAME_PERIOD(320), .NUM_BUFFERS(N), .HOLDOFF_CYCLES(H), .COUNT_WIDTH(W)) dut_long (
      .clk_in(clk), .rst_in(rst_l), .fb_ready_in(ready_l), .pixel_valid_in(valid_l), .done_in(done_l),
      .fb_switch_out(l_switch), .fb_clear_out(l_clear), .buffer_index_out(l_idx),
      .matrix_rst_out(l_matrix), .fetch_rst_out(l_fetch), .pixel_count_out(l_pix),
      .last_pixel_count_out(l_last), .frame_count_out(l_frame), .overrun_count_out(l_over)
   );

   task automatic check_output(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: outputs derived from cycles since reset and time since the last switch.
   int cyc, sw_at, pix, last, frames, over, acc, e_idx;
   bit rendering, awaiting, sw, model_valid = 1'b0;
   bit e_switch, e_matrix, e_fetch, e_clear;

   always @(posedge clk) begin
      if (rst) begin
         cyc = 0; sw_at = 0; pix = 0; last = 0; frames = 0; over = 0; e_idx = 0;
         rendering = 0; awaiting = 0;
         e_switch = 0; e_matrix = 0; e_fetch = 1; e_clear = 1;
         model_valid = 1'b1;
      end else begin
         cyc++;
         sw = (cyc % P == 0);
         e_switch = sw;
         e_clear  = sw;
         e_matrix = sw;
         e_idx    = (cyc / P) % N;
         if (rendering) begin
            acc = pix + (valid ? 1 : 0);
            if (acc > CMAX) acc = CMAX;
            pix = acc;
            if (done || sw) last = acc;
            if (sw && !done && over < CMAX) over++;
            if (sw || done) rendering = 0;
         end else if (awaiting && !sw && (cyc - sw_at) >= H + 1 && ready) begin
            awaiting  = 0;
            rendering = 1;
            e_fetch   = 0;
            frames    = (frames + 1) % 256;
            pix       = 0;
         end
         if (sw) begin
            awaiting  = 1;
            rendering = 0;
            sw_at     = cyc;
            e_fetch   = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         check_output("fb_switch", 32'(switch_o), 32'(e_switch));
         check_output("fb_clear", 32'(clear_o), 32'(e_clear));
         check_output("buffer_index", 32'(idx_o), e_idx);
         check_output("matrix_rst", 32'(matrix_o), 32'(e_matrix));
         check_output("fetch_rst", 32'(fetch_o), 32'(e_fetch));
         check_output("frame_count", 32'(frame_o), frames);
         check_output("pixel_count", 32'(pix_o), STATS ? pix : 0);
         check_output("last_pixel_count", 32'(last_o), STATS ? last : 0);
         check_output("overrun_count", 32'(over_o), STATS ? over : 0);
      end
   end

   task automatic goto_cycle(input int c);
      int guard = 0;
      while (cyc != c && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check_output("goto_cycle", cyc, c);
   endtask

   task automatic apply_stimulus();
      rst = 1; ready = 1; valid = 0; done = 0; rst_l = 1; valid_l = 0;
      repeat (3) @(negedge clk);
      check_output("reset_clear", 32'(clear_o), 1);
      check_output("reset_fetch", 32'(fetch_o), 1);
      rst = 0;

      // Switch cadence and the ready hold-off.
      goto_cycle(50);
      check_output("sw50_switch", 32'(switch_o), 1);
      check_output("sw50_clear", 32'(clear_o), 1);
      check_output("sw50_idx", 32'(idx_o), 1);
      check_output("sw50_matrix", 32'(matrix_o), 1);
      ready = 0;
      goto_cycle(51);
      check_output("c51_switch", 32'(switch_o), 0);
      check_output("c51_clear", 32'(clear_o), 0);
      goto_cycle(60);
      check_output("c60_fetch", 32'(fetch_o), 1);
      ready = 1;
      goto_cycle(61);
      check_output("c61_fetch", 32'(fetch_o), 0);
      check_output("c61_frame", 32'(frame_o), 1);

      // Twenty pixels then done.
      valid = 1;
      goto_cycle(81);
      valid = 0;
      goto_cycle(82);
      done = 1;
      goto_cycle(83);
      done = 0;
      check_output("last_20", 32'(last_o), STATS ? 20 : 0);
      check_output("over_0", 32'(over_o), 0);

      // No done across switches at 100 and 150.
      goto_cycle(100);
      check_output("sw100_idx", 32'(idx_o), 2);
      check_output("sw100_matrix", 32'(matrix_o), 1);
      goto_cycle(150);
      check_output("sw150_idx", 32'(idx_o), 0);
      check_output("sw150_matrix", 32'(matrix_o), 1);
      check_output("sw150_over", 32'(over_o), STATS ? 1 : 0);

      // Seven pixels, then done plus a pixel on the switch cycle.
      goto_cycle(159);
      valid = 1;
      goto_cycle(166);
      valid = 0;
      goto_cycle(199);
      valid = 1; done = 1;
      goto_cycle(200);
      valid = 0; done = 0;
      check_output("sw200_last", 32'(last_o), STATS ? 8 : 0);
      check_output("sw200_over", 32'(over_o), STATS ? 1 : 0);
      check_output("sw200_switch", 32'(switch_o), 1);

      // Reset in the middle of a rendered frame.
      goto_cycle(205);
      check_output("c205_frame", 32'(frame_o), 4);
      valid = 1;
      goto_cycle(212);
      check_output("c212_pix", 32'(pix_o), STATS ? 7 : 0);
      rst = 1;
      @(negedge clk);
      check_output("midrst_fetch", 32'(fetch_o), 1);
      check_output("midrst_clear", 32'(clear_o), 1);
      check_output("midrst_pix", 32'(pix_o), 0);
      check_output("midrst_frame", 32'(frame_o), 0);
      check_output("midrst_over", 32'(over_o), 0);
      check_output("midrst_last", 32'(last_o), 0);
      rst = 0; valid = 0;

      // Pixel counter saturation on the long-period instance.
      rst_l = 0;
      repeat (320) @(negedge clk);
      check_output("long_switch", 32'(l_switch), 1);
      check_output("long_clear", 32'(l_clear), 1);
      check_output("long_matrix", 32'(l_matrix), 1);
      check_output("long_idx", 32'(l_idx), 1);
      repeat (5) @(negedge clk);
      check_output("long_fetch", 32'(l_fetch), 0);
      check_output("long_frame", 32'(l_frame), 1);
      valid_l = 1;
      repeat (254) @(negedge clk);
      check_output("long_pix_254", 32'(l_pix), STATS ? 254 : 0);
      @(negedge clk);
      check_output("long_pix_255", 32'(l_pix), STATS ? 255 : 0);
      repeat (45) @(negedge clk);
      check_output("long_pix_sat", 32'(l_pix), STATS ? 255 : 0);
      check_output("long_over", 32'(l_over), 0);
      check_output("long_last", 32'(l_last), 0);
      rst_l = 1;
      @(negedge clk);
      check_output("long_rst_fetch", 32'(l_fetch), 1);
      check_output("long_rst_pix", 32'(l_pix), 0);
      check_output("long_rst_frame", 32'(l_frame), 0);
      check_output("long_rst_idx", 32'(l_idx), 0);
   endtask

   initial begin
      apply_stimulus();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
